// File: rtl/digit_sequencer_pkg.sv
// Shared constants and digit-advance rule for the digit sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package digit_sequencer_pkg;

    localparam int DIV_FAST_DEF = 10;
    localparam int DIV_SLOW_DEF = 1000;

    localparam logic [3:0] DEC_MAX = 4'd9;
    localparam logic [3:0] HEX_MAX = 4'd15;

    // io_in bit positions
    localparam int IO_CLK   = 0;
    localparam int IO_RST   = 1;
    localparam int IO_EN    = 2;
    localparam int IO_DIR   = 3;
    localparam int IO_RADIX = 4;
    localparam int IO_INV   = 5;
    localparam int IO_STEP  = 6;
    localparam int IO_RATE  = 7;

    typedef struct packed {
        logic       wrap;
        logic [3:0] digit;
    } adv_t;

    // Next digit for one advance. A decimal digit above 9 (left over from
    // hex mode) wraps to 0 going up, and drops to 9 without a wrap going down.
    function automatic adv_t advance(input logic [3:0] digit,
                                     input logic       up,
                                     input logic       hex);
        adv_t       res;
        logic [3:0] max_d;
        max_d     = hex ? HEX_MAX : DEC_MAX;
        res.wrap  = 1'b0;
        res.digit = digit;
        if (up) begin
            if (digit >= max_d) begin
                res.digit = 4'd0;
                res.wrap  = 1'b1;
            end else begin
                res.digit = digit + 4'd1;
            end
        end else begin
            if (digit == 4'd0) begin
                res.digit = max_d;
                res.wrap  = 1'b1;
            end else if (digit > max_d) begin
                res.digit = DEC_MAX;
            end else begin
                res.digit = digit - 4'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a strobe once per DIV_FAST/DIV_SLOW clocks.
// Latency: o_tick is combinational from the registered count (caller registers it).
// Backpressure: none; the count clears whenever i_en is low.
module tick_prescaler #(
    parameter int DIV_FAST = 10,
    parameter int DIV_SLOW = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_fast,
    output logic o_tick
);

    // Count never exceeds DIV_SLOW-1, assuming DIV_FAST <= DIV_SLOW.
    localparam int CW = (DIV_SLOW > 2) ? $clog2(DIV_SLOW) : 1;
    localparam logic [CW-1:0] FAST_LAST = CW'(DIV_FAST - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(DIV_SLOW - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_last;

    // ">=" rather than "==" so a switch to a shorter period never stalls.
    assign w_last = i_fast ? FAST_LAST : SLOW_LAST;
    assign o_tick = i_en && (r_cnt >= w_last);

    // Count up while enabled, restart on tick, hold at zero while disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_sequencer.sv
// Up/down decimal/hex digit counter advanced by prescaler ticks or a debounced-free step button.
// Latency: all outputs registered; digit/tick/wrap change one clock after the advance is sampled.
// Backpressure: none; coincident tick and step merge into a single advance.
module digit_sequencer
    import digit_sequencer_pkg::*;
#(
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int DIV_SLOW = DIV_SLOW_DEF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       w_clk;
    logic       w_rst;
    logic       w_tick;
    logic       w_step;
    logic       w_adv;
    adv_t       w_next;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_step_prev;
    logic [1:0] r_vld;
    logic       r_arm;

    logic [3:0] r_digit;
    logic       r_dp;
    logic       r_inv;
    logic       r_tick;
    logic       r_wrap;

    assign w_clk = io_in[IO_CLK];
    assign w_rst = io_in[IO_RST];

    tick_prescaler #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_prescaler (
        .i_clk  (w_clk),
        .i_rst  (w_rst),
        .i_en   (io_in[IO_EN]),
        .i_fast (io_in[IO_RATE]),
        .o_tick (w_tick)
    );

    // r_arm is only set once the synchronised button has been seen low with
    // post-reset data, so a button held through reset release is not a step.
    assign w_step = r_sync2 & ~r_step_prev & r_arm;
    assign w_adv  = w_tick | w_step;
    assign w_next = advance(r_digit, io_in[IO_DIR], io_in[IO_RADIX]);

    // Two-flop synchroniser, edge-detect history and post-reset arming.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_step_prev <= 1'b0;
            r_vld       <= 2'b00;
            r_arm       <= 1'b0;
        end else begin
            r_sync1     <= io_in[IO_STEP];
            r_sync2     <= r_sync1;
            r_step_prev <= r_sync2;
            r_vld       <= {r_vld[0], 1'b1};
            r_arm       <= r_arm | (r_vld[1] & ~r_sync2);
        end
    end

    // Digit counter and registered outputs; direction/radix matter only when advancing.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_digit <= 4'd0;
            r_dp    <= 1'b0;
            r_inv   <= 1'b0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_inv  <= io_in[IO_INV];
            if (w_adv) begin
                r_digit <= w_next.digit;
                r_wrap  <= w_next.wrap;
                r_dp    <= r_dp ^ w_next.wrap;
            end else begin
                r_wrap  <= 1'b0;
            end
        end
    end

    assign io_out = {r_wrap, r_tick, r_inv, r_dp, r_digit};

endmodule

// File: tb/tb_digit_sequencer.sv
// Self-checking bench for digit_sequencer with DIV_FAST=4, DIV_SLOW=8.
// Directed scenarios followed by random stimulus against a cycle-level reference model.
// Outputs are checked 2 time units after every rising edge.
module tb_digit_sequencer;

    localparam int DF = 4;
    localparam int DS = 8;

    logic       clk;
    logic       rst, en, up, hex, inv, btn, fast;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    int   m_cnt, m_digit;
    logic m_dp, m_inv, m_tick, m_wrap;
    logic btn_q[$];

    // observed pulse counters for scenario checks
    int obs_wraps, obs_ticks;

    assign io_in = {fast, btn, inv, hex, up, en, rst, clk};

    digit_sequencer #(.DIV_FAST(DF), .DIV_SLOW(DS)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model one rising edge from the inputs present at that edge.
    task automatic model_edge();
        logic tk, st;
        int   mx, div;
        if (rst) begin
            m_cnt = 0; m_digit = 0; m_dp = 0; m_inv = 0; m_tick = 0; m_wrap = 0;
            btn_q.delete();
        end else begin
            btn_q.push_back(btn);
            if (btn_q.size() > 8) void'(btn_q.pop_front());
            // a step is a 0->1 of the button seen two edges late, both samples post-reset
            st = (btn_q.size() >= 4) && btn_q[btn_q.size()-3] && !btn_q[btn_q.size()-4];
            div = fast ? DF : DS;
            tk = en && (m_cnt >= div - 1);
            if (!en || tk) m_cnt = 0;
            else           m_cnt = m_cnt + 1;
            m_tick = tk;
            m_inv  = inv;
            m_wrap = 1'b0;
            if (tk || st) begin
                mx = hex ? 15 : 9;
                if (up) begin
                    if (m_digit >= mx) begin m_digit = 0; m_wrap = 1'b1; end
                    else m_digit = m_digit + 1;
                end else begin
                    if (m_digit == 0)      begin m_digit = mx; m_wrap = 1'b1; end
                    else if (m_digit > mx) m_digit = 9;
                    else                   m_digit = m_digit - 1;
                end
            end
            m_dp = m_dp ^ m_wrap;
        end
    endtask

    // One clock: advance model at the edge, then compare every output field.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #2;
        chk("digit", {4'h0, io_out[3:0]}, 8'(m_digit));
        chk("dp",    {7'h0, io_out[4]},   {7'h0, m_dp});
        chk("inv",   {7'h0, io_out[5]},   {7'h0, m_inv});
        chk("tick",  {7'h0, io_out[6]},   {7'h0, m_tick});
        chk("wrap",  {7'h0, io_out[7]},   {7'h0, m_wrap});
        if (io_out[7]) obs_wraps++;
        if (io_out[6]) obs_ticks++;
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (3) cyc();
        btn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; hex = 1'b0; inv = 1'b1; btn = 1'b1; fast = 1'b1;

        // Reset state with button and invert held high; release with button still high.
        repeat (3) cyc();
        chk("reset_all", io_out, 8'h00);
        rst = 1'b0;
        repeat (6) cyc();
        chk("held_btn_no_step", {4'h0, io_out[3:0]}, 8'h00);
        btn = 1'b0; inv = 1'b0;
        repeat (3) cyc();

        // Decimal up-count at the fast rate: ten ticks bring 9->0 with one wrap.
        en = 1'b1; up = 1'b1; hex = 1'b0; fast = 1'b1;
        rst = 1'b1; cyc(); rst = 1'b0;
        obs_wraps = 0;
        repeat (40) cyc();
        chk("dec_cycle_digit", {4'h0, io_out[3:0]}, 8'h00);
        chk("dec_cycle_dp",    {7'h0, io_out[4]},   8'h01);
        chk("dec_cycle_wraps", 8'(obs_wraps),       8'h01);

        // Manual steps, down in hex with counting disabled: F, E, D.
        en = 1'b0; up = 1'b0; hex = 1'b1;
        do_reset();
        obs_wraps = 0; obs_ticks = 0;
        press(); chk("down_hex_1", {4'h0, io_out[3:0]}, 8'h0f);
        press(); chk("down_hex_2", {4'h0, io_out[3:0]}, 8'h0e);
        press(); chk("down_hex_3", {4'h0, io_out[3:0]}, 8'h0d);
        chk("down_hex_wraps", 8'(obs_wraps), 8'h01);
        chk("down_hex_ticks", 8'(obs_ticks), 8'h00);

        // Hex digit C then decimal step up -> 0 with wrap.
        up = 1'b1; hex = 1'b1;
        do_reset();
        repeat (12) press();
        chk("hex_c_up", {4'h0, io_out[3:0]}, 8'h0c);
        hex = 1'b0; obs_wraps = 0;
        press();
        chk("c_dec_up",       {4'h0, io_out[3:0]}, 8'h00);
        chk("c_dec_up_wraps", 8'(obs_wraps),       8'h01);
        // Same from C going down in decimal -> 9, no wrap.
        hex = 1'b1;
        do_reset();
        repeat (12) press();
        chk("hex_c_dn", {4'h0, io_out[3:0]}, 8'h0c);
        hex = 1'b0; up = 1'b0; obs_wraps = 0;
        press();
        chk("c_dec_dn",       {4'h0, io_out[3:0]}, 8'h09);
        chk("c_dec_dn_wraps", 8'(obs_wraps),       8'h00);

        // Step edge coincides with the second tick (edge 7 after release): one advance.
        en = 1'b1; up = 1'b1; hex = 1'b0; fast = 1'b1; btn = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn = (i >= 5 && i < 9);
            cyc();
        end
        chk("tick_step_merge", {4'h0, io_out[3:0]}, 8'h03);
        btn = 1'b0;

        // Slow rate, switch to fast when the count reaches 6: tick on that edge.
        fast = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            fast = (i >= 6);
            cyc();
            if (i == 5) chk("rate_no_tick_yet", {7'h0, io_out[6]}, 8'h00);
            if (i == 6) chk("rate_switch_tick", {7'h0, io_out[6]}, 8'h01);
            if (i == 10) chk("rate_restart_tick", {7'h0, io_out[6]}, 8'h01);
        end

        // Reset mid-count at digit 7 with dp and invert set.
        fast = 1'b1; inv = 1'b1;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (68) cyc();
        chk("pre_rst_digit", {4'h0, io_out[3:0]}, 8'h07);
        chk("pre_rst_dp",    {7'h0, io_out[4]},   8'h01);
        chk("pre_rst_inv",   {7'h0, io_out[5]},   8'h01);
        rst = 1'b1; cyc();
        chk("mid_rst_all", io_out, 8'h00);
        rst = 1'b0; cyc();
        chk("post_rst_inv",   {7'h0, io_out[5]},   8'h01);
        chk("post_rst_digit", {4'h0, io_out[3:0]}, 8'h00);

        // Random stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(99) == 0);
            en  = ($urandom_range(9) != 0);
            if ($urandom_range(3) == 0) btn  = ~btn;
            if ($urandom_range(7) == 0) up   = ~up;
            if ($urandom_range(7) == 0) hex  = ~hex;
            if ($urandom_range(7) == 0) inv  = ~inv;
            if ($urandom_range(15) == 0) fast = ~fast;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/digit_sequencer.md
DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 Parameter DIV_FAST, default 10: prescaler period in clocks when io_in[7]=1.
REQ-002 Parameter DIV_SLOW, default 1000: prescaler period in clocks when io_in[7]=0.
REQ-003 Port io_in[0]  input  1  clock; sole clock, all state on its rising edge.
REQ-004 Port io_in[1]  input  1  reset; synchronous, active-high.
REQ-005 Port io_in[2]  input  1  enable; 1 = free-run counting at the prescaled rate.
REQ-006 Port io_in[3]  input  1  direction; 1 = up, 0 = down.
REQ-007 Port io_in[4]  input  1  radix; 0 = decimal (0..9), 1 = hex (0..15).
REQ-008 Port io_in[5]  input  1  invert request; passed through to io_out[5].
REQ-009 Port io_in[6]  input  1  manual step button; asynchronous, rising edge advances by one.
REQ-010 Port io_in[7]  input  1  rate select; 1 = DIV_FAST, 0 = DIV_SLOW.
REQ-011 Port io_out[3:0]  output  4  current digit; bit-compatible with the downstream 7-segment decoder's digit inputs.
REQ-012 Port io_out[4]  output  1  dp; feeds the decoder's decimal-point input.
REQ-013 Port io_out[5]  output  1  invert; feeds the decoder's polarity input.
REQ-014 Port io_out[6]  output  1  tick; one-cycle prescaler strobe.
REQ-015 Port io_out[7]  output  1  wrap; one-cycle carry/borrow strobe.

Function
REQ-016 All outputs SHALL be registered; no combinational input-to-output path.
REQ-017 Prescaler SHALL count while enable=1 and SHALL clear to 0 while enable=0.
REQ-018 A tick SHALL be generated on the cycle the prescaler count is >= DIV-1, where DIV is the period selected by the current io_in[7]; the count SHALL clear to 0 on the same cycle.
REQ-019 A rate change mid-period SHALL therefore never stall; if the count already exceeds the new DIV-1, the tick fires on the next cycle.
REQ-020 io_in[6] SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; each detected edge is one step event.
REQ-021 An advance SHALL occur on the cycle of a tick or a step event; a simultaneous tick and step SHALL produce exactly one advance.
REQ-022 Up advance: digit==max gives 0 with wrap=1; otherwise digit+1. max = 9 (decimal) or 15 (hex).
REQ-023 Down advance: digit==0 gives max with wrap=1; otherwise digit-1.
REQ-024 In decimal mode, a digit >9 (left over from a hex-to-decimal switch) SHALL advance up to 0 with wrap=1, or down to 9 with wrap=0.
REQ-025 Digit, tick and wrap SHALL update one cycle after the advance condition is sampled.
REQ-026 dp SHALL toggle on every wrap and hold otherwise.
REQ-027 io_out[5] SHALL equal io_in[5] delayed by one clock.
REQ-028 Direction and radix SHALL be sampled on the advance cycle only; changes between advances have no effect on the held digit.

Reset
REQ-029 While reset=1: digit=0, dp=0, invert=0, tick=0, wrap=0, prescaler=0, synchroniser and edge-detect flops=0.
REQ-030 Reset SHALL override any coincident advance; after reset is released, the first tick occurs DIV cycles later with enable=1.
REQ-031 A step edge held high across reset release SHALL NOT generate a step.

Structure
REQ-032 A shared package SHALL hold DIV_FAST/DIV_SLOW defaults, DEC_MAX=9, HEX_MAX=15 and the io bit-index constants.
REQ-033 The prescaler SHALL be a sub-module, tick_prescaler (inputs: enable, rate select; output: tick), with width sized from DIV_SLOW.
REQ-034 The counter, edge detector and output registers SHALL live in digit_sequencer.

Verification
REQ-035 Run with DIV_FAST=4, DIV_SLOW=8, and with enable=1, up, decimal, fast: the digit SHALL step 0,1,...,9,0 every 4 clocks, wrap=1 only on 9->0, and dp SHALL toggle to 1.
REQ-036 Set down, hex, enable=0, then press step 3 times from 0: the digit SHALL go F,E,D, with exactly one wrap pulse on 0->F and tick never asserted.
REQ-037 Set up, hex, digit=C, then switch to decimal and press step: the digit SHALL become 0 with wrap=1; repeat with down from C: the digit SHALL become 9 with wrap=0.
REQ-038 Align a step edge on the same cycle as a tick: the digit SHALL advance exactly one value.
REQ-039 Switch the rate from slow to fast at prescaler count 6: tick SHALL fire on the next cycle and the count SHALL restart.
REQ-040 Assert reset mid-count at digit 7, dp=1, invert=1: all outputs SHALL read 0 on the following cycle, and io_out[5] SHALL track io_in[5] one cycle after release.
